instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Consumes decoded SPI instructions {opcode, key_addr, text_addr} from the deserializer through a valid/ready handshake.
//  Sequences the crypto job: key fetch, then text fetch, then accelerator run, then result write-back over a shared word bus.
//  Caches the last loaded key address so that repeated ops with the same key skip the key fetch.
//  Sits between the deserializer and the bus/accelerator; it is the only master of the bus.
// PARAMETERS
//  ADDRW        8    bus / instruction address width
//  OPCODEW      2    opcode width
//  BLOCK_WORDS  4    words per key, text and result block (power of 2, >=2)
//  TIMEOUT_CYC  256  max cycles in WAIT_DONE before error (>=2)
// PORTS
//  clk           in   1        system clock
//  rst_n         in   1        async active-low reset
//  in_valid      in   1        instruction valid (from deserializer valid_out)
//  in_ready      out  1        sequencer idle, can accept (to deserializer ready_in)
//  in_opcode     in   OPCODEW  00 NOP, 01 ENC, 10 DEC, 11 LOAD_KEY
//  in_key_addr   in   ADDRW    key block base address
//  in_text_addr  in   ADDRW    text/result block base address
//  bus_req       out  1        bus transfer request
//  bus_we        out  1        1=write (result), 0=read
//  bus_sel       out  2        target: 00 KEY, 01 TEXT, 10 RESULT
//  bus_addr      out  ADDRW    word address
//  bus_ack       in   1        transfer completes in a cycle where bus_req&&bus_ack
//  acc_start     out  1        1-cycle accelerator start pulse
//  acc_mode      out  1        0=encrypt, 1=decrypt (valid with acc_start)
//  acc_done      in   1        accelerator completion pulse
//  busy          out  1        state != IDLE
//  err           out  1        1-cycle pulse on accelerator timeout
//  key_cached    out  1        the key at the cached address is loaded in the accelerator
// BEHAVIOUR
//  Reset state: IDLE, word counter 0, timeout counter 0, cache invalid.
//   All outputs are 0 except in_ready=1. rst_n asserted mid-job aborts at once: bus_req drops asynchronously.
//  in_ready = (state==IDLE). Fields are latched on in_valid&&in_ready; the FSM leaves IDLE on the next edge.
//  States: IDLE -> FETCH_KEY | FETCH_TEXT | IDLE(NOP); FETCH_KEY -> FETCH_TEXT | IDLE(LOAD_KEY);
//   FETCH_TEXT -> START -> WAIT_DONE -> WRITE_BACK | ERROR; WRITE_BACK -> IDLE; ERROR -> IDLE.
//  NOP: accepted, no bus activity, back to IDLE next cycle.
//  ENC/DEC: FETCH_KEY is skipped when key_cached && key_addr==cached_addr.
//  Bus: registered outputs. bus_req is high in FETCH_*/WRITE_BACK; addr/sel/we stay stable until ack.
//   On ack the word index increments; the next word is presented the following cycle (back-to-back allowed).
//   After BLOCK_WORDS acks the phase ends. bus_req is 0 in the cycle the state changes.
//  bus_addr = base + idx, mod 2^ADDRW (wraps 0xFF -> 0x00).
//  Zero-wait bus: each phase takes BLOCK_WORDS cycles.
//  START: acc_start=1 and acc_mode=opcode[1] for exactly one cycle.
//  WAIT_DONE: the counter counts cycles from 0.
//   acc_done -> WRITE_BACK.
//   Counter reaching TIMEOUT_CYC-1 without done -> ERROR.
//   done in the same cycle as timeout: done wins.
//  acc_done outside WAIT_DONE is ignored.
//  ERROR: err=1 for one cycle, cache invalidated, no write-back, then IDLE.
//  LOAD_KEY and a completed key fetch set cached_addr=key_addr and key_cached=1.
//  busy is registered, matching state.
// STRUCTURE
//  Package ctrl_pkg:
//   opcode_e {OP_NOP, OP_ENC, OP_DEC, OP_LOAD_KEY}
//   state_e (7 states)
//   bus_sel_e {SEL_KEY, SEL_TEXT, SEL_RESULT}
//  Sub-module burst_addr_gen: loads the base, counts acks, outputs addr and last_word. Shared by all three phases.
// TESTING (BLOCK_WORDS=4, zero-wait ack unless stated)
//  ENC key=0x10 text=0x40, done 5 cycles after start ->
//   KEY reads 0x10-0x13, TEXT reads 0x40-0x43, one acc_start with mode 0, RESULT writes 0x40-0x43, then in_ready=1.
//  DEC key=0x10 text=0x80 following the first job ->
//   no KEY transfers, key_cached=1, mode 1, RESULT writes 0x80-0x83.
//  Ack every 3rd cycle -> addr/sel/we unchanged while req&&!ack; exactly 4 transfers per phase.
//  LOAD_KEY key=0xFE -> reads 0xFE,0xFF,0x00,0x01; no acc_start; key_cached=1.
//  acc_done never arrives (TIMEOUT_CYC=16) -> err pulse 16 cycles after START, no writes.
//   key_cached=0 afterwards; the next ENC refetches the key.
//  in_valid held high during a job -> no second accept until IDLE.
//  rst_n low during FETCH_TEXT -> outputs at reset values immediately; a new job after reset starts with a key fetch.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// Shared types for the instruction sequencer: opcodes, FSM states, bus targets
// and two small decode helpers used to build the registered bus outputs.
package ctrl_pkg;

  typedef enum logic [1:0] {
    OP_NOP      = 2'b00,
    OP_ENC      = 2'b01,
    OP_DEC      = 2'b10,
    OP_LOAD_KEY = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_KEY,
    S_FETCH_TEXT,
    S_START,
    S_WAIT_DONE,
    S_WRITE_BACK,
    S_ERROR
  } state_e;

  typedef enum logic [1:0] {
    SEL_KEY    = 2'b00,
    SEL_TEXT   = 2'b01,
    SEL_RESULT = 2'b10
  } bus_sel_e;

  // States in which the sequencer owns an active bus phase.
  function automatic logic is_bus_state(state_e s);
    return (s == S_FETCH_KEY) || (s == S_FETCH_TEXT) || (s == S_WRITE_BACK);
  endfunction

  // Bus target presented while in a given state.
  function automatic bus_sel_e sel_for_state(state_e s);
    case (s)
      S_FETCH_TEXT: return SEL_TEXT;
      S_WRITE_BACK: return SEL_RESULT;
      default:      return SEL_KEY;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction handshake, word bus and accelerator control bundled together.
// master = the sequencer, slave = deserializer / bus fabric / accelerator side.
interface instr_sequencer_if #(
  parameter int ADDRW   = 8,
  parameter int OPCODEW = 2
);
  import ctrl_pkg::*;

  logic               in_valid;
  logic               in_ready;
  logic [OPCODEW-1:0] in_opcode;
  logic [ADDRW-1:0]   in_key_addr;
  logic [ADDRW-1:0]   in_text_addr;

  logic               bus_req;
  logic               bus_we;
  bus_sel_e           bus_sel;
  logic [ADDRW-1:0]   bus_addr;
  logic               bus_ack;

  logic               acc_start;
  logic               acc_mode;
  logic               acc_done;

  modport master (
    input  in_valid, in_opcode, in_key_addr, in_text_addr, bus_ack, acc_done,
    output in_ready, bus_req, bus_we, bus_sel, bus_addr, acc_start, acc_mode
  );

  modport slave (
    output in_valid, in_opcode, in_key_addr, in_text_addr, bus_ack, acc_done,
    input  in_ready, bus_req, bus_we, bus_sel, bus_addr, acc_start, acc_mode
  );

endinterface

// File: rtl/instr_sequencer_burst_addr_gen.sv
// Burst address generator shared by the key, text and result phases.
// Loads a base address, steps once per acknowledged word and flags the last
// word of the block. The address is held in a flop so the bus sees a
// registered value that only moves on an ack or a new load.
module burst_addr_gen #(
  parameter int ADDRW       = 8,
  parameter int BLOCK_WORDS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [ADDRW-1:0] base_i,
  input  logic             inc_i,
  output logic [ADDRW-1:0] addr_o,
  output logic             last_word_o
);

  localparam int IDX_W = $clog2(BLOCK_WORDS);

  logic [ADDRW-1:0] addr_q;
  logic [IDX_W-1:0] idx_q;

  // Load wins over increment so a phase hand-over on the final ack starts clean.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      idx_q  <= '0;
    end else if (load_i) begin
      addr_q <= base_i;
      idx_q  <= '0;
    end else if (inc_i) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      addr_q <= addr_q + 1'b1;  // wraps modulo 2^ADDRW
      idx_q  <= idx_q + 1'b1;
    end
  end

  assign addr_o      = addr_q;
  assign last_word_o = (idx_q == IDX_W'(BLOCK_WORDS - 1));

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: accepts decoded instructions, fetches key and text
// blocks, runs the accelerator with a timeout and writes the result back.
// The last loaded key address is cached so repeated ops skip the key fetch.
module instr_sequencer
  import ctrl_pkg::*;
#(
  parameter int ADDRW       = 8,
  parameter int OPCODEW     = 2,
  parameter int BLOCK_WORDS = 4,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  instr_sequencer_if.master   sif,
  output logic                busy,
  output logic                err,
  output logic                key_cached
);

  localparam int TMO_W = $clog2(TIMEOUT_CYC);

  state_e           state_q, state_d;
  opcode_e          op_q;
  logic [ADDRW-1:0] key_addr_q, text_addr_q, cached_addr_q;
  logic             key_cached_q;
  logic [TMO_W-1:0] tmo_q;

  logic             in_ready_q, busy_q, err_q;
  logic             bus_req_q, bus_we_q;
  bus_sel_e         bus_sel_q;
  logic             acc_start_q, acc_mode_q;

  logic [OPCODEW-1:0] opc_raw;
  opcode_e            in_op;
  logic               accept, key_hit, xfer, phase_done;
  logic               ag_load, ag_last;
  logic [ADDRW-1:0]   ag_base, ag_addr;

  assign opc_raw    = sif.in_opcode;
  assign in_op      = opcode_e'(opc_raw[1:0]);
  assign accept     = in_ready_q && sif.in_valid;
  assign key_hit    = key_cached_q && (sif.in_key_addr == cached_addr_q);
  assign xfer       = bus_req_q && sif.bus_ack;
  assign phase_done = xfer && ag_last;

  burst_addr_gen #(
    .ADDRW       (ADDRW),
    .BLOCK_WORDS (BLOCK_WORDS)
  ) u_addr_gen (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ag_load),
    .base_i      (ag_base),
    .inc_i       (xfer),
    .addr_o      (ag_addr),
    .last_word_o (ag_last)
  );

  // Next state and the address-generator load that opens each bus phase.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case leaves it unassigned (which would infer a latch).
    state_d = state_q;
    ag_load = 1'b0;
    ag_base = text_addr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          case (in_op)
            OP_NOP: state_d = S_IDLE;
            OP_LOAD_KEY: begin
              state_d = S_FETCH_KEY;
              ag_load = 1'b1;
              ag_base = sif.in_key_addr;
            end
            default: begin
              ag_load = 1'b1;
              if (key_hit) begin
                state_d = S_FETCH_TEXT;
                ag_base = sif.in_text_addr;
              end else begin
                state_d = S_FETCH_KEY;
                ag_base = sif.in_key_addr;
              end
            end
          endcase
        end
      end
      S_FETCH_KEY: begin
        if (phase_done) begin
          if (op_q == OP_LOAD_KEY) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_FETCH_TEXT;
            ag_load = 1'b1;
          end
        end
      end
      S_FETCH_TEXT: if (phase_done) state_d = S_START;
      S_START:      state_d = S_WAIT_DONE;
      S_WAIT_DONE: begin
        // A done in the timeout cycle is still honoured.
        if (sif.acc_done) begin
          state_d = S_WRITE_BACK;
          ag_load = 1'b1;
        end else if (tmo_q == TMO_W'(TIMEOUT_CYC - 2)) begin
          state_d = S_ERROR;
        end
      end
      S_WRITE_BACK: if (phase_done) state_d = S_IDLE;
      S_ERROR:      state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // State, latched instruction, key cache, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      key_addr_q    <= '0;
      text_addr_q   <= '0;
      cached_addr_q <= '0;
      key_cached_q  <= 1'b0;
      tmo_q         <= '0;
      in_ready_q    <= 1'b1;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_sel_q     <= SEL_KEY;
      acc_start_q   <= 1'b0;
      acc_mode_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        op_q        <= in_op;
        key_addr_q  <= sif.in_key_addr;
        text_addr_q <= sif.in_text_addr;
      end

      // Counts cycles spent in WAIT_DONE, starting from 0 on entry.
      tmo_q <= (state_q == S_WAIT_DONE && state_d == S_WAIT_DONE) ? tmo_q + 1'b1 : '0;

      if (state_q == S_FETCH_KEY && phase_done) begin
        cached_addr_q <= key_addr_q;
        key_cached_q  <= 1'b1;
      end else if (state_d == S_ERROR) begin
        key_cached_q  <= 1'b0;
      end

      in_ready_q  <= (state_d == S_IDLE);
      busy_q      <= (state_d != S_IDLE);
      err_q       <= (state_d == S_ERROR);
      bus_req_q   <= is_bus_state(state_d);
      bus_we_q    <= (state_d == S_WRITE_BACK);
      bus_sel_q   <= sel_for_state(state_d);
      acc_start_q <= (state_d == S_START);
      acc_mode_q  <= (state_d == S_START) && (op_q == OP_DEC);
    end
  end

  assign sif.in_ready  = in_ready_q;
  assign sif.bus_req   = bus_req_q;
  assign sif.bus_we    = bus_we_q;
  assign sif.bus_sel   = bus_sel_q;
  assign sif.bus_addr  = ag_addr;
  assign sif.acc_start = acc_start_q;
  assign sif.acc_mode  = acc_mode_q;
  assign busy          = busy_q;
  assign err           = err_q;
  assign key_cached    = key_cached_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: a table of jobs with hand-computed
// transfer counts/addresses, plus hand-written held-valid and mid-job reset
// sequences. A negedge process acts as bus slave and accelerator and logs
// every completed transfer.
module tb_instr_sequencer;
  import ctrl_pkg::*;

  localparam int TIMEOUT = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, err, key_cached;

  instr_sequencer_if #(.ADDRW(8), .OPCODEW(2)) sif ();

  instr_sequencer #(
    .ADDRW       (8),
    .OPCODEW     (2),
    .BLOCK_WORDS (4),
    .TIMEOUT_CYC (TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sif        (sif),
    .busy       (busy),
    .err        (err),
    .key_cached (key_cached)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic       we;
    logic [7:0] addr;
  } xfer_t;

  typedef struct {
    opcode_e    op;
    logic [7:0] key;
    logic [7:0] text;
    int         ack_period;
    int         done_delay;   // 0 = accelerator never answers
    int         exp_key_n;
    int         exp_text_n;
    int         exp_wr_n;
    int         exp_start_n;
    logic       exp_mode;
    int         exp_err_n;
    logic       exp_cached;
  } vec_t;

  int errors = 0;
  int checks = 0;

  // Monitor / responder state
  int    cyc = 0;
  int    ack_period = 1;
  int    done_delay = 0;
  int    done_cnt = 0;
  int    n_start = 0, n_err = 0;
  int    start_cyc = 0, err_cyc = 0;
  logic  start_mode = 1'b0;
  xfer_t xq[$];
  logic  hold_prev = 1'b0;
  logic [11:0] prev_bus = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    xq.delete();
    n_start = 0; n_err = 0; start_cyc = 0; err_cyc = 0;
    start_mode = 1'b0; done_cnt = 0;
  endtask

  // Bus slave + accelerator model, sampled and driven away from the active edge.
  initial begin
    sif.bus_ack  = 1'b0;
    sif.acc_done = 1'b0;
    forever begin
      logic ack_now;
      @(negedge clk);
      cyc++;
      sif.acc_done = 1'b0;
      if (done_cnt > 0) begin
        done_cnt--;
        if (done_cnt == 0) sif.acc_done = 1'b1;
      end
      if (sif.acc_start) begin
        n_start++;
        start_cyc  = cyc;
        start_mode = sif.acc_mode;
        if (done_delay > 0) done_cnt = done_delay;
      end
      if (err) begin
        n_err++;
        err_cyc = cyc;
      end
      ack_now = ((cyc % ack_period) == 0);
      sif.bus_ack = ack_now;
      if (hold_prev)
        check("bus_hold", {20'd0, sif.bus_req, sif.bus_we, sif.bus_sel, sif.bus_addr}, {20'd0, prev_bus});
      if (sif.bus_req) begin
        if (ack_now) xq.push_back('{sif.bus_sel, sif.bus_we, sif.bus_addr});
        hold_prev = !ack_now;
        prev_bus  = {1'b1, sif.bus_we, sif.bus_sel, sif.bus_addr};
      end else begin
        hold_prev = 1'b0;
      end
    end
  end

  task automatic check_job(input int idx, input vec_t v);
    int kn = 0, tn = 0, wn = 0;
    foreach (xq[i]) begin
      xfer_t x = xq[i];
      case (x.sel)
        SEL_KEY: begin
          check($sformatf("v%0d_key_xfer%0d", idx, kn), {23'd0, x.we, x.addr}, {23'd0, 1'b0, v.key + 8'(kn)});
          kn++;
        end
        SEL_TEXT: begin
          check($sformatf("v%0d_text_xfer%0d", idx, tn), {23'd0, x.we, x.addr}, {23'd0, 1'b0, v.text + 8'(tn)});
          tn++;
        end
        SEL_RESULT: begin
          check($sformatf("v%0d_wr_xfer%0d", idx, wn), {23'd0, x.we, x.addr}, {23'd0, 1'b1, v.text + 8'(wn)});
          wn++;
        end
        default: check($sformatf("v%0d_bad_sel", idx), 32'(x.sel), 32'(SEL_KEY));
      endcase
    end
    check($sformatf("v%0d_key_count", idx),  kn, v.exp_key_n);
    check($sformatf("v%0d_text_count", idx), tn, v.exp_text_n);
    check($sformatf("v%0d_wr_count", idx),   wn, v.exp_wr_n);
    check($sformatf("v%0d_starts", idx),     n_start, v.exp_start_n);
    check($sformatf("v%0d_mode", idx),       32'(start_mode), 32'(v.exp_mode));
    check($sformatf("v%0d_err_pulses", idx), n_err, v.exp_err_n);
    check($sformatf("v%0d_key_cached", idx), 32'(key_cached), 32'(v.exp_cached));
    if (v.exp_err_n > 0)
      check($sformatf("v%0d_err_latency", idx), err_cyc - start_cyc, TIMEOUT);
  endtask

  task automatic run_job(input int idx, input vec_t v);
    int n = 0;
    ack_period = v.ack_period;
    done_delay = v.done_delay;
    clear_log();
    check($sformatf("v%0d_ready_before", idx), 32'(sif.in_ready), 32'd1);
    sif.in_valid     = 1'b1;
    sif.in_opcode    = v.op;
    sif.in_key_addr  = v.key;
    sif.in_text_addr = v.text;
    @(negedge clk);
    sif.in_valid = 1'b0;
    while (!sif.in_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("v%0d_ready_after", idx), 32'(sif.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    check_job(idx, v);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"},   32'(sif.in_ready),  32'd1);
    check({tag, "_bus_req"},    32'(sif.bus_req),   32'd0);
    check({tag, "_bus_addr"},   32'(sif.bus_addr),  32'd0);
    check({tag, "_busy"},       32'(busy),          32'd0);
    check({tag, "_err"},        32'(err),           32'd0);
    check({tag, "_acc_start"},  32'(sif.acc_start), 32'd0);
    check({tag, "_key_cached"}, 32'(key_cached),    32'd0);
  endtask

  vec_t vecs[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int   n;
    //           op           key    text   ack done  key txt wr st mode err cached
    vecs[0] = '{OP_ENC,      8'h10, 8'h40, 1,  5,    4,  4,  4, 1, 1'b0, 0, 1'b1};
    vecs[1] = '{OP_DEC,      8'h10, 8'h80, 1,  5,    0,  4,  4, 1, 1'b1, 0, 1'b1};
    vecs[2] = '{OP_ENC,      8'h20, 8'h30, 3,  3,    4,  4,  4, 1, 1'b0, 0, 1'b1};
    vecs[3] = '{OP_LOAD_KEY, 8'hFE, 8'h00, 1,  5,    4,  0,  0, 0, 1'b0, 0, 1'b1};
    vecs[4] = '{OP_NOP,      8'h00, 8'h00, 1,  5,    0,  0,  0, 0, 1'b0, 0, 1'b1};
    vecs[5] = '{OP_ENC,      8'hFE, 8'h50, 1,  0,    0,  4,  0, 1, 1'b0, 1, 1'b0};
    vecs[6] = '{OP_ENC,      8'hFE, 8'h50, 1,  2,    4,  4,  4, 1, 1'b0, 0, 1'b1};

    sif.in_valid     = 1'b0;
    sif.in_opcode    = 2'b00;
    sif.in_key_addr  = 8'h00;
    sif.in_text_addr = 8'h00;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_reset");

    for (int i = 0; i < 7; i++) run_job(i, vecs[i]);

    // in_valid held across a whole job with changing fields: only one accept.
    ack_period = 1;
    done_delay = 2;
    clear_log();
    sif.in_valid     = 1'b1;
    sif.in_opcode    = OP_ENC;
    sif.in_key_addr  = 8'hFE;
    sif.in_text_addr = 8'h60;
    @(negedge clk);
    sif.in_key_addr  = 8'h33;
    sif.in_text_addr = 8'h70;
    n = 0;
    while (!sif.in_ready && n < 400) begin
      @(negedge clk);
      check("hold_busy_not_ready", 32'(sif.in_ready & busy), 32'd0);
      n++;
    end
    sif.in_valid = 1'b0;
    check("hold_ready_after", 32'(sif.in_ready), 32'd1);
    repeat (2) @(negedge clk);
    v = '{OP_ENC, 8'hFE, 8'h60, 1, 2, 0, 4, 4, 1, 1'b0, 0, 1'b1};
    check_job(7, v);

    // Reset in the middle of the text fetch aborts the job immediately.
    ack_period = 1;
    done_delay = 5;
    clear_log();
    sif.in_valid     = 1'b1;
    sif.in_opcode    = OP_ENC;
    sif.in_key_addr  = 8'h10;
    sif.in_text_addr = 8'h90;
    @(negedge clk);
    sif.in_valid = 1'b0;
    n = 0;
    while (!(sif.bus_req && sif.bus_sel == SEL_TEXT) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("abort_in_text_phase", 32'(sif.bus_sel), 32'(SEL_TEXT));
    check("abort_cached_before", 32'(key_cached), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("abort");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    v = '{OP_ENC, 8'h10, 8'h90, 1, 5, 4, 4, 4, 1, 1'b0, 0, 1'b1};
    run_job(8, v);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
